ram_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the shared single-port synchronous RAM used in the HW8 memory work. It grants one requester per clock, drives the RAM write enable, address and write data, and returns read data one cycle after a granted read. An optional lock lets the granted requester hold the RAM for back-to-back accesses. The block sits between two client engines and the RAM, which it instantiates.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/sync_ram.sv | 36 +++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
// Ownership states and requester identifiers used by the grant logic.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered read address.
// Read data follows the latched address, so a write is visible to a read issued on the next edge.
module sync_ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] r_addr;

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (i_re) begin
      r_addr <= i_addr;
    end
  end

  assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with optional lock between two clients and a shared sync_ram.
// Grants are combinational; the granted access executes at the following rising edge.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic                  i_a_lock,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic                  i_b_lock,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_a_gnt,
  output logic                  o_b_gnt,
  output logic                  o_a_rvalid,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  state_t r_state;
  state_t w_state_next;
  logic   r_prio;
  logic   w_prio_next;
  logic   w_gnt_a;
  logic   w_gnt_b;
  logic   w_a_gnt;
  logic   w_b_gnt;
  logic   r_a_rvalid;
  logic   r_b_rvalid;
  logic   w_ram_we;
  logic   w_ram_re;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= FREE;
      r_prio  <= REQ_A;
    end else begin
      r_state <= w_state_next;
      r_prio  <= w_prio_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    case (r_state)
      FREE: begin
        if (i_a_req && (!i_b_req || r_prio == REQ_A)) begin
          w_gnt_a     = 1'b1;
          w_prio_next = REQ_B;
          if (i_a_lock) w_state_next = LOCK_A;
        end else if (i_b_req) begin
          w_gnt_b     = 1'b1;
          w_prio_next = REQ_A;
          if (i_b_lock) w_state_next = LOCK_B;
        end
      end
      // An owner that drops req gives up the RAM and the next turn.
      LOCK_A: begin
        if (i_a_req) begin
          w_gnt_a = 1'b1;
          if (!i_a_lock) w_state_next = FREE;
        end else begin
          w_state_next = FREE;
          w_prio_next  = REQ_B;
        end
      end
      LOCK_B: begin
        if (i_b_req) begin
          w_gnt_b = 1'b1;
          if (!i_b_lock) w_state_next = FREE;
        end else begin
          w_state_next = FREE;
          w_prio_next  = REQ_A;
        end
      end
      default: w_state_next = FREE;
    endcase
  end

  // Reset masks the grants so nothing reaches the RAM while reset_n is low.
  assign w_a_gnt = w_gnt_a & i_reset_n;
  assign w_b_gnt = w_gnt_b & i_reset_n;
  assign o_a_gnt = w_a_gnt;
  assign o_b_gnt = w_b_gnt;

  assign w_ram_we    = (w_a_gnt & i_a_we) | (w_b_gnt & i_b_we);
  assign w_ram_re    = (w_a_gnt & ~i_a_we) | (w_b_gnt & ~i_b_we);
  assign w_ram_addr  = w_b_gnt ? i_b_addr : i_a_addr;
  assign w_ram_wdata = w_b_gnt ? i_b_wdata : i_a_wdata;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt & ~i_a_we;
      r_b_rvalid <= w_b_gnt & ~i_b_we;
    end
  end

  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;

  sync_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_n),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (o_rdata)
  );

endmodule
